// File: rtl/gb_mem_pkg.sv
// gb_mem_pkg -- shared memory-map constants and DMA state type.
//   DMA_REG_ADDR : OAM DMA source-page register address
//   OAM_BASE     : first byte of object attribute memory
//   HIGH_PAGE    : page served by the high-page bus, never blocked by DMA
//   dma_state_e  : OAM DMA controller states
package gb_mem_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [7:0]  HIGH_PAGE    = 8'hFF;

  // Decoder T-states of interest; an M-cycle ends on the T4 edge.
  localparam logic [1:0]  T_T2 = 2'b01;
  localparam logic [1:0]  T_T4 = 2'b11;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'd0,
    DMA_ARM  = 2'd1,
    DMA_XFER = 2'd2
  } dma_state_e;

  function automatic logic in_high_page(input logic [15:0] addr);
    return addr[15:8] == HIGH_PAGE;
  endfunction

endpackage

// File: rtl/oam_dma_addr_gen.sv
// oam_dma_addr_gen -- byte index and source/destination address generation.
// Build option: OAM_DMA_ECHO_REMAP_EN maps source pages E0-FF down to C0-DF
// (echo RAM); otherwise the source page is used unmodified.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   idx_clr, idx_inc : restart index at 0 / advance index (clear wins)
//   src_hi           : source page register
//   idx              : current byte index
//   src_addr         : address read in T1-T2
//   dst_addr         : OAM address written in T3-T4
module oam_dma_addr_gen
  import gb_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        idx_clr,
  input  logic        idx_inc,
  input  logic [7:0]  src_hi,
  output logic [7:0]  idx,
  output logic [15:0] src_addr,
  output logic [15:0] dst_addr
);

  logic [7:0] idx_d, idx_q;
  logic [7:0] src_page;

  always_comb begin
    idx_d = idx_q;
    if (idx_clr) begin
      idx_d = 8'h00;
    end else if (idx_inc) begin
      idx_d = idx_q + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 8'h00;
    end else begin
      idx_q <= idx_d;
    end
  end

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign src_page = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
`else
  assign src_page = src_hi;
`endif

  assign idx      = idx_q;
  assign src_addr = {src_page, idx_q};
  assign dst_addr = OAM_BASE + {8'h00, idx_q};

endmodule

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter -- OAM DMA engine and CPU/DMA memory bus arbiter.
// Build option: OAM_DMA_ECHO_REMAP_EN (see oam_dma_addr_gen).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; CPU owns the memory bus
// ARM   | source written; one M-cycle of startup latency
// XFER  | one byte per M-cycle: read T1-T2, write OAM T3-T4
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   t_cycle                  : decoder T-state (0=T1 .. 3=T4)
//   cpu_addr/rd/wr/wdata     : CPU bus request
//   cpu_rdata, cpu_blocked   : CPU read data, CPU access suppressed
//   mem_addr/rd/wr/wdata     : arbitrated memory bus, mem_rdata back
//   mem_ctrl_sel, dma_active : DMA owns bus, DMA armed or transferring
module oam_dma_arbiter
  import gb_mem_pkg::*;
#(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_blocked,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ctrl_sel,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e  state_d, state_q;
  logic [7:0]  src_hi_d, src_hi_q;
  logic [7:0]  byte_d, byte_q;
  logic        idx_clr, idx_inc;
  logic [7:0]  idx;
  logic [15:0] src_addr, dst_addr;
  logic        reg_wr_hit, reg_rd_hit, m_end, xfer;

  assign m_end      = (t_cycle == T_T4);
  assign reg_wr_hit = cpu_wr && (cpu_addr == DMA_REG_ADDR) && m_end;
  assign reg_rd_hit = cpu_rd && (cpu_addr == DMA_REG_ADDR);

  oam_dma_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .idx_clr  (idx_clr),
    .idx_inc  (idx_inc),
    .src_hi   (src_hi_q),
    .idx      (idx),
    .src_addr (src_addr),
    .dst_addr (dst_addr)
  );

  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    byte_d   = byte_q;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    case (state_q)
      DMA_IDLE: ;
      DMA_ARM: begin
        if (m_end) state_d = DMA_XFER;
      end
      DMA_XFER: begin
        if (t_cycle == T_T2) byte_d = mem_rdata;
        if (m_end) begin
          idx_inc = 1'b1;
          if (idx == LAST_IDX) state_d = DMA_IDLE;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
    // A register write lands on the T4 edge, after the current byte's OAM
    // write has been driven, so restarting here never truncates a byte.
    if (reg_wr_hit) begin
      src_hi_d = cpu_wdata;
      idx_clr  = 1'b1;
      state_d  = DMA_ARM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DMA_IDLE;
      src_hi_q <= 8'h00;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      byte_q   <= byte_d;
    end
  end

  // Outputs are gated by rst so an aborted transfer issues no bus cycle
  // even in the cycle reset is being applied.
  assign xfer         = (state_q == DMA_XFER) && !rst;
  assign mem_ctrl_sel = xfer;
  assign dma_active   = (state_q != DMA_IDLE) && !rst;
  assign cpu_blocked  = xfer && (cpu_rd || cpu_wr) && !in_high_page(cpu_addr);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_rd    = cpu_rd && !rst;
    mem_wr    = cpu_wr && !rst;
    mem_wdata = cpu_wdata;
    if (xfer) begin
      mem_wdata = byte_q;
      if (!t_cycle[1]) begin
        mem_addr = src_addr;
        mem_rd   = 1'b1;
        mem_wr   = 1'b0;
      end else begin
        mem_addr = dst_addr;
        mem_rd   = 1'b0;
        mem_wr   = 1'b1;
      end
    end
  end

  always_comb begin
    cpu_rdata = mem_rdata;
    if (reg_rd_hit) begin
      cpu_rdata = src_hi_q;
    end else if (cpu_blocked) begin
      cpu_rdata = 8'hFF;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;

  localparam int DMA_LEN = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  t_cycle;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_blocked;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ctrl_sel, dma_active;

  logic [7:0] mem  [0:65535];
  logic [7:0] gold [0:65535];

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  oam_dma_arbiter #(.DMA_LEN(DMA_LEN)) dut (
    .clk(clk), .rst(rst), .t_cycle(t_cycle),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_blocked(cpu_blocked),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ctrl_sel(mem_ctrl_sel), .dma_active(dma_active)
  );

  int checks = 0;
  int errors = 0;

  // Reference: m_pos = -2 idle, -1 waiting one M-cycle, 0..DMA_LEN-1 byte being moved.
  int         m_pos = -2;
  logic [7:0] m_src = 8'h00;
  logic [7:0] m_byte = 8'h00;
  int         tc = 0;

  logic       last_active, last_sel, last_blocked;
  logic [7:0] last_rdata;

  function automatic logic [7:0] pat(input int a);
    logic [15:0] x;
    logic [7:0]  hi;
    x  = a[15:0];
    hi = x[15:8];
    return x[7:0] ^ (hi * 8'd7) ^ 8'h3C;
  endfunction

  function automatic int src_page(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (s >= 8'hE0) return int'(s) - 32;
`endif
    return int'(s);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  // One clock: compare outputs against the reference, then advance both.
  task automatic tick();
    logic        wr_en;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic        sel_e, blk_e;
    t_cycle = tc[1:0];
    #1;
    last_active = dma_active; last_sel = mem_ctrl_sel;
    last_blocked = cpu_blocked; last_rdata = cpu_rdata;
    if (rst) begin
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_sel", mem_ctrl_sel, 0);
      check("rst_active", dma_active, 0);
      check("rst_blocked", cpu_blocked, 0);
    end else begin
      sel_e = (m_pos >= 0);
      check("dma_active", dma_active, int'(m_pos >= -1));
      check("mem_ctrl_sel", mem_ctrl_sel, int'(sel_e));
      if (sel_e) begin
        blk_e = (cpu_rd || cpu_wr) && (cpu_addr < 16'hFF00);
        if (tc < 2) begin
          check("dma_rd_addr", mem_addr, src_page(m_src) * 256 + m_pos);
          check("dma_rd", mem_rd, 1);
          check("dma_rd_wr", mem_wr, 0);
        end else begin
          check("dma_wr_addr", mem_addr, 16'hFE00 + m_pos);
          check("dma_wr_rd", mem_rd, 0);
          check("dma_wr", mem_wr, 1);
          check("dma_wdata", mem_wdata, m_byte);
        end
      end else begin
        blk_e = 1'b0;
        check("pass_addr", mem_addr, cpu_addr);
        check("pass_rd", mem_rd, cpu_rd);
        check("pass_wr", mem_wr, cpu_wr);
        if (cpu_wr) check("pass_wdata", mem_wdata, cpu_wdata);
      end
      check("cpu_blocked", cpu_blocked, int'(blk_e));
      if (cpu_rd) begin
        if (cpu_addr == 16'hFF46)      check("ff46_rdata", cpu_rdata, m_src);
        else if (blk_e)                check("blocked_rdata", cpu_rdata, 8'hFF);
        else if (!sel_e)               check("pass_rdata", cpu_rdata, gold[cpu_addr]);
      end
    end
    wr_en = mem_wr; wa = mem_addr; wd = mem_wdata;
    @(posedge clk);
    if (rst) begin
      m_pos = -2; m_src = 8'h00; m_byte = 8'h00;
    end else begin
      if (m_pos >= 0) begin
        if (tc >= 2)      gold[16'hFE00 + m_pos] = m_byte;
        else if (tc == 1) m_byte = gold[src_page(m_src) * 256 + m_pos];
      end else if (cpu_wr) begin
        gold[cpu_addr] = cpu_wdata;
      end
      if (tc == 3) begin
        if (cpu_wr && cpu_addr == 16'hFF46) begin
          m_src = cpu_wdata;
          m_pos = -1;
        end else if (m_pos >= -1) begin
          m_pos++;
          if (m_pos == DMA_LEN) m_pos = -2;
        end
      end
    end
    if (wr_en) mem[wa] = wd;
    tc = (tc + 1) % 4;
    @(negedge clk);
  endtask

  task automatic write_ff46(input logic [7:0] d);
    idle_in();
    for (int g = 0; g < 8 && tc != 3; g++) tick();
    cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = d;
    tick();
    idle_in();
  endtask

  task automatic run_until_idle(output int n_act, output int n_sel);
    n_act = 0; n_sel = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (last_active) n_act++;
      if (last_sel) n_sel++;
      if (!last_active) break;
    end
  endtask

  task automatic wait_model(input int pos, input int t);
    for (int g = 0; g < 3000 && !(m_pos == pos && tc == t); g++) tick();
  endtask

  initial begin
    int n_act, n_sel, errs, page;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = pat(a);
      gold[a] = pat(a);
    end
    rst = 1'b1;
    t_cycle = 2'b00;
    idle_in();
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 16'hFF46;
    tick();
    check("ff46_after_reset", last_rdata, 8'h00);
    check("active_after_reset", last_active, 0);

    // C1 transfer with FF46, C000 and FF80 reads along the way.
    write_ff46(8'hC1);
    n_act = 0; n_sel = 0;
    for (int i = 0; i < 3000; i++) begin
      cpu_rd = 1'b1;
      if (i < 100)      cpu_addr = 16'hFF46;
      else if (i < 200) cpu_addr = 16'hC000;
      else if (i < 300) cpu_addr = 16'hFF80;
      else              cpu_addr = 16'hFF46;
      tick();
      if (i == 1) begin
        check("ff46_in_arm", last_rdata, 8'hC1);
        check("arm_active", last_active, 1);
        check("arm_sel", last_sel, 0);
      end
      if (i == 50)  check("ff46_in_xfer", last_rdata, 8'hC1);
      if (i == 150) begin
        check("c000_blocked", last_blocked, 1);
        check("c000_rdata", last_rdata, 8'hFF);
      end
      if (i == 250) check("ff80_not_blocked", last_blocked, 0);
      if (last_active) n_act++;
      if (last_sel) n_sel++;
      if (!last_active) break;
    end
    check("c1_active_clks", n_act, 644);
    check("c1_sel_clks", n_sel, 640);
    errs = 0;
    for (int k = 0; k < 160; k++) if (mem[16'hFE00 + k] != pat(16'hC100 + k)) errs++;
    check("oam_copy_c1", errs, 0);
    check("fea0_untouched", mem[16'hFEA0], pat(16'hFEA0));
    cpu_rd = 1'b1; cpu_addr = 16'hFF46;
    tick();
    check("ff46_in_idle", last_rdata, 8'hC1);

    // Restart at idx 50.
    write_ff46(8'hC1);
    wait_model(50, 3);
    cpu_wr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'hC2;
    tick();
    idle_in();
    run_until_idle(n_act, n_sel);
    check("restart_active_clks", n_act, 644);
    errs = 0;
    for (int k = 0; k < 160; k++) if (mem[16'hFE00 + k] != pat(16'hC200 + k)) errs++;
    check("oam_copy_c2", errs, 0);

    // Reset mid-transfer at idx 80.
    for (int k = 0; k < 160; k++) begin
      mem[16'hFE00 + k] = 8'hEE;
      gold[16'hFE00 + k] = 8'hEE;
    end
    write_ff46(8'hC3);
    wait_model(80, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_active", last_active, 0);
    check("post_rst_sel", last_sel, 0);
    repeat (20) tick();
    errs = 0;
    for (int k = 0; k < 80; k++) if (mem[16'hFE00 + k] != pat(16'hC300 + k)) errs++;
    check("rst_oam_head", errs, 0);
    errs = 0;
    for (int k = 80; k < 160; k++) if (mem[16'hFE00 + k] != 8'hEE) errs++;
    check("rst_oam_tail_untouched", errs, 0);

    // Echo page source.
    write_ff46(8'hE3);
    run_until_idle(n_act, n_sel);
`ifdef OAM_DMA_ECHO_REMAP_EN
    page = 16'hC300;
`else
    page = 16'hE300;
`endif
    errs = 0;
    for (int k = 0; k < 160; k++) if (mem[16'hFE00 + k] != pat(page + k)) errs++;
    check("oam_copy_e3", errs, 0);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      int r, s;
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 5);
      cpu_rd = (r < 40);
      cpu_wr = (r >= 40 && r < 70);
      cpu_wdata = 8'($urandom);
      case (s)
        0: cpu_addr = 16'hC000 + 16'($urandom_range(0, 1023));
        1: cpu_addr = 16'hFE00 + 16'($urandom_range(0, 255));
        2: cpu_addr = 16'hFF80 + 16'($urandom_range(0, 127));
        3: cpu_addr = 16'hFF46;
        4: cpu_addr = 16'hE000 + 16'($urandom_range(0, 1023));
        default: cpu_addr = 16'($urandom);
      endcase
      if (cpu_wr && cpu_addr == 16'hFF46 && $urandom_range(0, 299) != 0) begin
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
      end
      rst = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    for (int g = 0; g < 1000 && m_pos != -2; g++) tick();
    check("drain_idle", m_pos, -2);
    errs = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] != gold[a]) errs++;
    check("memory_image", errs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, meaning bytes per OAM DMA transfer.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port t_cycle  input  2  decoder T-state (00=T1 .. 11=T4).
REQ-005 SHALL have ports cpu_addr  input  16, cpu_rd  input  1, cpu_wr  input  1, cpu_wdata  input  8: CPU bus request.
REQ-006 SHALL have port cpu_rdata  output  8  read data returned to CPU.
REQ-007 SHALL have port cpu_blocked  output  1  CPU access this M-cycle is suppressed.
REQ-008 SHALL have ports mem_addr  output  16, mem_rd  output  1, mem_wr  output  1, mem_wdata  output  8: arbitrated memory bus.
REQ-009 SHALL have port mem_rdata  input  8  memory read data.
REQ-010 SHALL have ports mem_ctrl_sel  output  1 (1 = DMA owns bus) and dma_active  output  1.

Function
REQ-011 SHALL hold an 8-bit source register src_hi; a CPU write is taken when cpu_wr=1, cpu_addr=16'hFF46 and t_cycle=11 at the clock edge.
REQ-012 SHALL return src_hi on cpu_rdata when cpu_rd=1 and cpu_addr=16'hFF46, in every state.
REQ-013 SHALL implement states IDLE, ARM, XFER; a write to FF46 in any state loads src_hi, clears the index to 0 and enters ARM.
REQ-014 SHALL leave ARM for XFER at the next t_cycle=11 edge, giving exactly one M-cycle of startup latency.
REQ-015 SHALL, in XFER, move one byte per M-cycle: T1-T2 drive mem_addr={src_hi,idx}, mem_rd=1; T3-T4 drive mem_addr=16'hFE00+idx, mem_wr=1, mem_wdata=latched byte.
REQ-016 SHALL latch mem_rdata into the byte latch at the t_cycle=01 edge in XFER.
REQ-017 SHALL increment idx (8-bit) at each t_cycle=11 edge in XFER; after the write of idx=DMA_LEN-1 it SHALL return to IDLE, for DMA_LEN M-cycles in XFER in total.
REQ-018 SHALL drive mem_ctrl_sel=1 only in XFER; dma_active=1 in ARM and XFER.
REQ-019 SHALL, outside XFER, pass cpu_addr/cpu_rd/cpu_wr/cpu_wdata to the mem bus and mem_rdata to cpu_rdata combinationally.
REQ-020 SHALL, in XFER, assert cpu_blocked when (cpu_rd|cpu_wr) and cpu_addr<=16'hFEFF; blocked reads return 8'hFF and blocked writes are dropped.
REQ-021 SHALL never block cpu_addr in FF00-FFFF; these are served by the high-page bus outside this block, except FF46 (REQ-012).
REQ-022 SHALL give priority to restart when an FF46 write coincides with the final XFER byte: the final byte completes, then the block goes to ARM, not IDLE.

Reset
REQ-023 SHALL on rst set state=IDLE, src_hi=8'h00, idx=0 and byte latch=8'h00; outputs mem_ctrl_sel=0, dma_active=0, cpu_blocked=0, mem_rd=0, mem_wr=0.
REQ-024 SHALL abort an in-progress ARM/XFER on rst with no further DMA bus cycles.

Configuration
REQ-025 SHALL honour macro OAM_DMA_ECHO_REMAP_EN: when defined, src_hi>=8'hE0 reads from {src_hi-8'h20,idx}; when undefined, the source address is {src_hi,idx} unmodified.

Structure
REQ-026 SHALL take DMA_REG_ADDR (16'hFF46), OAM_BASE (16'hFE00), HIGH_PAGE (8'hFF) and the state enum from shared package gb_mem_pkg.
REQ-027 SHALL place source/destination address generation (idx, remap) in sub-module oam_dma_addr_gen.

Verification
REQ-028 SHALL cover: write 8'hC1 to FF46 -> ARM 1 M-cycle, then 160 XFER M-cycles copying C100-C19F to FE00-FE9F, dma_active clears after the last write.
REQ-029 SHALL cover: CPU read of 16'hC000 during XFER -> cpu_blocked=1, cpu_rdata=8'hFF; CPU read of 16'hFF80 -> cpu_blocked=0.
REQ-030 SHALL cover: write 8'hC2 to FF46 at idx=50 -> restart at idx=0 from C200, 1 + 160 further M-cycles.
REQ-031 SHALL cover: rst at idx=80 -> next cycle IDLE, mem_ctrl_sel=0, FE50 onward untouched.
REQ-032 SHALL cover: write 8'hE3 with OAM_DMA_ECHO_REMAP_EN -> reads from C300-C39F; without the macro -> reads from E300-E39F.
REQ-033 SHALL cover: FF46 read after writing 8'hC1 -> 8'hC1 in IDLE, ARM and XFER.
